// File: rtl/f2_fetch_queue_if.sv
// Bundle of the fetch-stage-2 queue's handshake and bus signals: the fetch packet in,
// the decode slots out, the resteer requests in and the redirect to F1 out.
interface f2_fetch_queue_if #(
  parameter int XLEN    = 32,
  parameter int CL_SIZE = 128,
  parameter int DEPTH   = 4,
  parameter int ISSUE_W = 2
);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic                    fetch_valid;
  logic                    fetch_ready;
  logic [XLEN-1:0]         fetch_pc;
  logic [CL_SIZE-1:0]      data_even;
  logic [CL_SIZE-1:0]      data_odd;
  logic                    hit_even;
  logic                    hit_odd;
  logic                    fetch_exc;

  logic [ISSUE_W-1:0]      dec_valid;
  logic [32*ISSUE_W-1:0]   dec_instr;
  logic [XLEN*ISSUE_W-1:0] dec_pc;
  logic [ISSUE_W-1:0]      dec_exc;
  logic                    dec_ready;

  logic                    rsteer_rob_taken;
  logic                    rsteer_d1_taken;
  logic                    rsteer_br_taken;
  logic                    rsteer_ras_taken;
  logic [XLEN-1:0]         rsteer_rob_target;
  logic [XLEN-1:0]         rsteer_d1_target;
  logic [XLEN-1:0]         rsteer_br_target;
  logic [XLEN-1:0]         rsteer_ras_target;

  logic                    redirect_valid;
  logic [XLEN-1:0]         redirect_pc;
  logic [OCC_W-1:0]        occupancy;

  modport master (
    output fetch_valid, fetch_pc, data_even, data_odd, hit_even, hit_odd, fetch_exc,
    output dec_ready,
    output rsteer_rob_taken, rsteer_d1_taken, rsteer_br_taken, rsteer_ras_taken,
    output rsteer_rob_target, rsteer_d1_target, rsteer_br_target, rsteer_ras_target,
    input  fetch_ready, dec_valid, dec_instr, dec_pc, dec_exc,
    input  redirect_valid, redirect_pc, occupancy
  );

  modport slave (
    input  fetch_valid, fetch_pc, data_even, data_odd, hit_even, hit_odd, fetch_exc,
    input  dec_ready,
    input  rsteer_rob_taken, rsteer_d1_taken, rsteer_br_taken, rsteer_ras_taken,
    input  rsteer_rob_target, rsteer_d1_target, rsteer_br_target, rsteer_ras_target,
    output fetch_ready, dec_valid, dec_instr, dec_pc, dec_exc,
    output redirect_valid, redirect_pc, occupancy
  );
endinterface

// File: rtl/f2_fetch_queue.sv
// Fetch-stage-2 line queue: stores whole I-cache lines in a circular buffer, extracts up to
// ISSUE_W instructions per cycle toward decode, and flushes/redirects on a prioritised resteer.
module f2_fetch_queue #(
  parameter int XLEN    = 32,
  parameter int CL_SIZE = 128,
  parameter int DEPTH   = 4,
  parameter int ISSUE_W = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  f2_fetch_queue_if.slave  io_fq
);
  localparam int LB  = CL_SIZE / 8;
  localparam int OB  = $clog2(LB);
  localparam int WPL = CL_SIZE / 32;
  localparam int WB  = $clog2(WPL);
  localparam int PW  = $clog2(DEPTH);

  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [PW:0]   OCC_ONE   = (PW+1)'(1);
  localparam logic [PW:0]   OCC_TWO   = (PW+1)'(2);
  localparam logic [PW:0]   OCC_DEPTH = (PW+1)'(DEPTH);
  localparam logic [WB-1:0] WORD_ONE  = WB'(1);
  localparam logic [WB-1:0] WORD_LAST = WB'(WPL - 1);

  logic [CL_SIZE-1:0] r_data  [DEPTH];
  logic [XLEN-1:0]    r_base  [DEPTH];
  logic [WB-1:0]      r_start [DEPTH];
  logic [DEPTH-1:0]   r_exc;
  logic [PW-1:0]      r_head;
  logic [PW-1:0]      r_tail;
  logic [PW:0]        r_occ;
  logic [WB-1:0]      r_off;
  logic               r_redir_v;
  logic [XLEN-1:0]    r_redir_pc;

  logic               w_rsteer;
  logic [XLEN-1:0]    w_win_pc;
  logic               w_odd;
  logic               w_prim_hit;
  logic               w_sec_hit;
  logic [CL_SIZE-1:0] w_prim_data;
  logic [CL_SIZE-1:0] w_sec_data;
  logic [XLEN-1:0]    w_prim_base;
  logic [XLEN-1:0]    w_sec_base;
  logic [WB-1:0]      w_prim_start;
  logic [PW:0]        w_free;
  logic               w_ready;
  logic               w_push;
  logic               w_push2;
  logic [2:0]         w_push_cnt;
  logic [2:0]         w_pops;
  logic [2:0]         w_pop_cnt;
  logic               w_deq;
  logic [WB-1:0]      w_off_nxt;
  logic [PW-1:0]      w_idx;
  logic [WB-1:0]      w_off;
  logic [PW:0]        w_avail;
  logic               w_stop;

  logic [ISSUE_W-1:0]      w_dec_valid;
  logic [32*ISSUE_W-1:0]   w_dec_instr;
  logic [XLEN*ISSUE_W-1:0] w_dec_pc;
  logic [ISSUE_W-1:0]      w_dec_exc;

  // Resteer arbitration: ROB beats D1 beats BR beats RAS.
  always_comb begin
    w_rsteer = 1'b0;
    w_win_pc = '0;
    if (io_fq.rsteer_rob_taken) begin
      w_rsteer = 1'b1;
      w_win_pc = io_fq.rsteer_rob_target;
    end else if (io_fq.rsteer_d1_taken) begin
      w_rsteer = 1'b1;
      w_win_pc = io_fq.rsteer_d1_target;
    end else if (io_fq.rsteer_br_taken) begin
      w_rsteer = 1'b1;
      w_win_pc = io_fq.rsteer_br_target;
    end else if (io_fq.rsteer_ras_taken) begin
      w_rsteer = 1'b1;
      w_win_pc = io_fq.rsteer_ras_target;
    end else begin
      w_rsteer = 1'b0;
      w_win_pc = '0;
    end
  end

  assign w_odd        = io_fq.fetch_pc[OB];
  assign w_prim_hit   = w_odd ? io_fq.hit_odd   : io_fq.hit_even;
  assign w_sec_hit    = w_odd ? io_fq.hit_even  : io_fq.hit_odd;
  assign w_prim_data  = w_odd ? io_fq.data_odd  : io_fq.data_even;
  assign w_sec_data   = w_odd ? io_fq.data_even : io_fq.data_odd;
  assign w_prim_base  = {io_fq.fetch_pc[XLEN-1:OB], {OB{1'b0}}};
  assign w_sec_base   = w_prim_base + XLEN'(LB);
  assign w_prim_start = io_fq.fetch_pc[OB-1:2];

  // A packet may enqueue two lines, so two free entries are needed to accept it.
  assign w_free  = OCC_DEPTH - r_occ;
  assign w_ready = (w_free >= OCC_TWO) && !w_rsteer;
  assign w_push  = io_fq.fetch_valid && w_ready && w_prim_hit;
  assign w_push2 = w_push && w_sec_hit;

  // Number of lines written this cycle.
  always_comb begin
    if (w_push2) begin
      w_push_cnt = 3'd2;
    end else if (w_push) begin
      w_push_cnt = 3'd1;
    end else begin
      w_push_cnt = 3'd0;
    end
  end

  // Slot extraction: walk words from the head, crossing lines, stopping after an exception slot.
  always_comb begin
    w_dec_valid = '0;
    w_dec_instr = '0;
    w_dec_pc    = '0;
    w_dec_exc   = '0;
    w_pops      = 3'd0;
    w_idx       = r_head;
    w_off       = r_off;
    w_avail     = r_occ;
    w_stop      = 1'b0;
    for (int i = 0; i < ISSUE_W; i++) begin
      if (!w_stop && (w_avail != '0)) begin
        w_dec_valid[i]              = 1'b1;
        w_dec_instr[32*i +: 32]     = r_data[w_idx][{w_off, 5'd0} +: 32];
        w_dec_pc[XLEN*i +: XLEN]    = r_base[w_idx] + XLEN'({w_off, 2'b00});
        w_dec_exc[i]                = r_exc[w_idx];
        w_stop                      = r_exc[w_idx];
        if (w_off == WORD_LAST) begin
          w_idx   = w_idx + PTR_ONE;
          w_avail = w_avail - OCC_ONE;
          w_pops  = w_pops + 3'd1;
          w_off   = r_start[w_idx];
        end else begin
          w_off   = w_off + WORD_ONE;
        end
      end else begin
        w_stop = 1'b1;
      end
    end
    w_off_nxt = w_off;
  end

  assign w_deq     = w_dec_valid[0] && io_fq.dec_ready && !w_rsteer;
  assign w_pop_cnt = w_deq ? w_pops : 3'd0;

  // Line storage; contents are only observed while counted in occupancy, so no reset.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_data[r_tail]  <= w_prim_data;
      r_base[r_tail]  <= w_prim_base;
      r_start[r_tail] <= w_prim_start;
      r_exc[r_tail]   <= io_fq.fetch_exc;
    end
    if (w_push2) begin
      r_data[r_tail + PTR_ONE]  <= w_sec_data;
      r_base[r_tail + PTR_ONE]  <= w_sec_base;
      r_start[r_tail + PTR_ONE] <= {WB{1'b0}};
      r_exc[r_tail + PTR_ONE]   <= io_fq.fetch_exc;
    end
  end

  // Queue control: pointers, occupancy, head word offset and the one-cycle redirect.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_occ      <= '0;
      r_off      <= '0;
      r_redir_v  <= 1'b0;
      r_redir_pc <= '0;
    end else if (w_rsteer) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_occ      <= '0;
      r_off      <= '0;
      r_redir_v  <= 1'b1;
      r_redir_pc <= w_win_pc;
    end else begin
      r_redir_v <= 1'b0;
      r_occ     <= r_occ + (PW+1)'(w_push_cnt) - (PW+1)'(w_pop_cnt);
      r_tail    <= r_tail + PW'(w_push_cnt);
      r_head    <= r_head + PW'(w_pop_cnt);
      // A pushed line becomes head when everything older drains this cycle.
      if (w_push && (r_occ == (PW+1)'(w_pop_cnt))) begin
        r_off <= w_prim_start;
      end else if (w_deq) begin
        r_off <= w_off_nxt;
      end else begin
        r_off <= r_off;
      end
    end
  end

  assign io_fq.fetch_ready    = w_ready;
  assign io_fq.dec_valid      = w_dec_valid;
  assign io_fq.dec_instr      = w_dec_instr;
  assign io_fq.dec_pc         = w_dec_pc;
  assign io_fq.dec_exc        = w_dec_exc;
  assign io_fq.redirect_valid = r_redir_v;
  assign io_fq.redirect_pc    = r_redir_pc;
  assign io_fq.occupancy      = r_occ;
endmodule

// File: tb/tb_f2_fetch_queue.sv
// Scoreboard bench for f2_fetch_queue: accepted packets expand into an expected word stream,
// a negedge monitor compares decode slots, occupancy, ready and redirect against it.
module tb_f2_fetch_queue;
  localparam int XLEN = 32;
  localparam int CL   = 128;
  localparam int DEPTH = 4;
  localparam int IW   = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  f2_fetch_queue_if #(.XLEN(XLEN), .CL_SIZE(CL), .DEPTH(DEPTH), .ISSUE_W(IW)) fq ();
  f2_fetch_queue #(.XLEN(XLEN), .CL_SIZE(CL), .DEPTH(DEPTH), .ISSUE_W(IW)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .io_fq  (fq)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
    logic        last;
  } word_t;

  word_t       exp_q[$];
  int          lines = 0;
  logic        exp_rv = 1'b0;
  logic [31:0] exp_rpc = 32'h0;
  logic        exp_ready = 1'b0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          mon_n;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic any_rsteer();
    return fq.rsteer_rob_taken | fq.rsteer_d1_taken | fq.rsteer_br_taken | fq.rsteer_ras_taken;
  endfunction

  function automatic logic [31:0] winner();
    logic [31:0] t [4];
    logic        v [4];
    v[0] = fq.rsteer_rob_taken; t[0] = fq.rsteer_rob_target;
    v[1] = fq.rsteer_d1_taken;  t[1] = fq.rsteer_d1_target;
    v[2] = fq.rsteer_br_taken;  t[2] = fq.rsteer_br_target;
    v[3] = fq.rsteer_ras_taken; t[3] = fq.rsteer_ras_target;
    for (int k = 3; k >= 0; k--) if (v[k]) winner = t[k];
  endfunction

  // Expand an accepted packet into the words decode should see, in program order.
  task automatic push_packet();
    logic [31:0]  pc;
    logic [31:0]  base;
    logic [127:0] pd;
    logic [127:0] sd;
    logic         ph;
    logic         sh;
    word_t        w;
    pc   = fq.fetch_pc;
    base = pc & ~32'h0000_000F;
    ph   = pc[4] ? fq.hit_odd : fq.hit_even;
    sh   = pc[4] ? fq.hit_even : fq.hit_odd;
    pd   = pc[4] ? fq.data_odd : fq.data_even;
    sd   = pc[4] ? fq.data_even : fq.data_odd;
    if (ph) begin
      for (int k = int'(pc[3:2]); k < 4; k++) begin
        w.pc = base + 32'(4 * k); w.instr = pd[32*k +: 32]; w.exc = fq.fetch_exc; w.last = (k == 3);
        exp_q.push_back(w);
      end
      lines++;
      if (sh) begin
        for (int k = 0; k < 4; k++) begin
          w.pc = base + 32'h10 + 32'(4 * k); w.instr = sd[32*k +: 32]; w.exc = fq.fetch_exc; w.last = (k == 3);
          exp_q.push_back(w);
        end
        lines++;
      end
    end
  endtask

  // Recorder: applies what happens at each rising edge to the reference stream.
  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.delete(); lines = 0; exp_rv = 1'b0; exp_ready = 1'b0;
    end else if (any_rsteer()) begin
      exp_q.delete(); lines = 0; exp_rv = 1'b1; exp_rpc = winner();
    end else begin
      exp_rv = 1'b0;
      if (fq.fetch_valid && exp_ready) push_packet();
    end
  end

  // Monitor: compares the DUT view between edges and retires consumed words.
  always @(negedge clk) begin
    if (rst_n) begin
      mon_n = 0;
      for (int i = 0; i < IW; i++)
        if (i == mon_n && i < exp_q.size()) begin
          mon_n++;
          if (exp_q[i].exc) mon_n = IW + 1;
        end
      if (mon_n > IW) begin
        mon_n = 0;
        for (int i = 0; i < IW; i++) if (i == mon_n && !(i > 0 && exp_q[i-1].exc)) mon_n++;
      end
      check("dec_valid", 64'(fq.dec_valid), 64'((1 << mon_n) - 1));
      for (int i = 0; i < IW; i++) if (i < mon_n) begin
        check("dec_pc", 64'(fq.dec_pc[32*i +: 32]), 64'(exp_q[i].pc));
        check("dec_instr", 64'(fq.dec_instr[32*i +: 32]), 64'(exp_q[i].instr));
        check("dec_exc", 64'(fq.dec_exc[i]), 64'(exp_q[i].exc));
      end
      check("occupancy", 64'(fq.occupancy), 64'(lines));
      exp_ready = ((DEPTH - lines) >= 2) && !any_rsteer();
      check("fetch_ready", 64'(fq.fetch_ready), 64'(exp_ready));
      check("redirect_valid", 64'(fq.redirect_valid), 64'(exp_rv));
      if (exp_rv) check("redirect_pc", 64'(fq.redirect_pc), 64'(exp_rpc));
      if (fq.dec_ready && mon_n > 0 && !any_rsteer())
        repeat (mon_n) begin
          if (exp_q[0].last) lines--;
          void'(exp_q.pop_front());
        end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fq.fetch_valid = 1'b0; fq.fetch_pc = 32'h0; fq.data_even = '0; fq.data_odd = '0;
    fq.hit_even = 1'b0; fq.hit_odd = 1'b0; fq.fetch_exc = 1'b0; fq.dec_ready = 1'b0;
    fq.rsteer_rob_taken = 1'b0; fq.rsteer_d1_taken = 1'b0;
    fq.rsteer_br_taken = 1'b0;  fq.rsteer_ras_taken = 1'b0;
    fq.rsteer_rob_target = 32'h0; fq.rsteer_d1_target = 32'h0;
    fq.rsteer_br_target = 32'h0;  fq.rsteer_ras_target = 32'h0;
  endtask

  task automatic set_pkt(input logic [31:0] pc, input logic he, input logic ho, input logic exc);
    fq.fetch_valid = 1'b1; fq.fetch_pc = pc; fq.hit_even = he; fq.hit_odd = ho; fq.fetch_exc = exc;
    fq.data_even = {$urandom, $urandom, $urandom, $urandom};
    fq.data_odd  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_accept();
    logic acc;
    acc = 1'b0;
    for (int k = 0; k < 40 && !acc; k++) begin
      @(negedge clk);
      acc = fq.fetch_ready;
      tick();
    end
    if (!acc) check("accept_timeout", 64'd0, 64'd1);
    fq.fetch_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] pc, input logic he, input logic ho, input logic exc);
    set_pkt(pc, he, ho, exc);
    wait_accept();
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_occupancy", 64'(fq.occupancy), 64'd0);
    check("reset_dec_valid", 64'(fq.dec_valid), 64'd0);
    check("reset_redirect_valid", 64'(fq.redirect_valid), 64'd0);
    check("reset_redirect_pc", 64'(fq.redirect_pc), 64'd0);
    #1 rst_n = 1'b1;
    #1 check("ready_after_reset", 64'(fq.fetch_ready), 64'd1);
    tick();

    // Aligned pair, then odd-primary start and a line crossing inside one cycle.
    fq.dec_ready = 1'b1;
    send(32'h100, 1'b1, 1'b1, 1'b0); repeat (5) tick();
    send(32'h118, 1'b1, 1'b1, 1'b0); repeat (4) tick();
    send(32'h11C, 1'b1, 1'b1, 1'b0); repeat (4) tick();
    send(32'h130, 1'b1, 1'b0, 1'b0); repeat (3) tick();

    // Backpressure: fill, hold a third packet, then drain.
    fq.dec_ready = 1'b0;
    send(32'h300, 1'b1, 1'b1, 1'b0);
    send(32'h320, 1'b1, 1'b1, 1'b0);
    set_pkt(32'h348, 1'b1, 1'b1, 1'b0);
    repeat (3) tick();
    fq.dec_ready = 1'b1;
    wait_accept();
    repeat (12) tick();

    // Two resteers with a fetch and a dequeue in flight.
    send(32'h500, 1'b1, 1'b1, 1'b0);
    set_pkt(32'h540, 1'b1, 1'b1, 1'b0);
    fq.rsteer_br_taken = 1'b1;  fq.rsteer_br_target = 32'h400;
    fq.rsteer_rob_taken = 1'b1; fq.rsteer_rob_target = 32'h800;
    tick();
    fq.rsteer_br_taken = 1'b0; fq.rsteer_rob_taken = 1'b0; fq.fetch_valid = 1'b0;
    repeat (3) tick();

    // Exception packet: one slot per cycle.
    send(32'h200, 1'b1, 1'b1, 1'b1); repeat (10) tick();

    // Randomised traffic.
    for (int c = 0; c < 800; c++) begin
      set_pkt(32'h1000 + ($urandom_range(0, 255) << 2), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
      fq.fetch_valid = ($urandom_range(0, 2) != 0);
      fq.dec_ready = ($urandom_range(0, 9) < 7);
      fq.rsteer_rob_taken = ($urandom_range(0, 39) == 0); fq.rsteer_rob_target = $urandom & ~32'h3;
      fq.rsteer_d1_taken  = ($urandom_range(0, 39) == 0); fq.rsteer_d1_target  = $urandom & ~32'h3;
      fq.rsteer_br_taken  = ($urandom_range(0, 39) == 0); fq.rsteer_br_target  = $urandom & ~32'h3;
      fq.rsteer_ras_taken = ($urandom_range(0, 39) == 0); fq.rsteer_ras_target = $urandom & ~32'h3;
      tick();
    end
    idle();
    fq.dec_ready = 1'b1;
    repeat (12) tick();

    // Asynchronous reset while lines are queued.
    fq.dec_ready = 1'b0;
    send(32'h600, 1'b1, 1'b1, 1'b0);
    tick();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_reset_occupancy", 64'(fq.occupancy), 64'd0);
    check("async_reset_dec_valid", 64'(fq.dec_valid), 64'd0);
    check("async_reset_redirect", 64'(fq.redirect_valid), 64'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    fq.dec_ready = 1'b1;
    send(32'h700, 1'b1, 1'b0, 1'b0);
    repeat (6) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
